// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin, packet-locking arbiter sharing one UART TX serializer among NUM_REQ byte streams.
// Latency: grant 1 cycle after req_valid_i; first byte on tx_valid_o 2 cycles after req_valid_i.
// Backpressure: owner ready = output register empty or draining; tx_valid_o/tx_data_o hold while tx_ready_i is low.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = 8,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      tx_valid_o,
  output logic [DATA_W-1:0]         tx_data_o,
  input  logic                      tx_ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int OW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW   = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam int TMAX = (HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0;
  localparam logic [OW-1:0] LAST_RST = OW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TMAX);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t              state, state_nxt;
  logic [OW-1:0]       owner, owner_nxt;
  logic [OW-1:0]       last_owner, last_owner_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                tx_valid_nxt;
  logic [DATA_W-1:0]   tx_data_nxt;

  logic                own_valid, own_last;
  logic [DATA_W-1:0]   own_data;
  logic [NUM_REQ-1:0]  own_onehot;
  logic [OW-1:0]       pick_hi, pick_lo, pick;
  logic                found_hi;
  logic                out_free, hs;

  // Select the current owner's valid/last/data and its one-hot grant vector
  always_comb begin
    own_valid  = 1'b0;
    own_last   = 1'b0;
    own_data   = '0;
    own_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner == OW'(k)) begin
        own_valid     = req_valid_i[k];
        own_last      = req_last_i[k];
        own_data      = req_data_i[k*DATA_W +: DATA_W];
        own_onehot[k] = 1'b1;
      end
    end
  end

  // Round-robin pick: lowest requester above last_owner, else lowest overall (wrap)
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        pick_lo = OW'(k);
        if (OW'(k) > last_owner) begin
          pick_hi  = OW'(k);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  // FSM next-state, output register next value and handshake outputs
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    cnt_nxt        = cnt;
    tx_valid_nxt   = tx_valid_o;
    tx_data_nxt    = tx_data_o;
    out_free       = !tx_valid_o || tx_ready_i;
    grant_o        = '0;
    req_ready_o    = '0;
    hs             = 1'b0;

    if (state == LOCK) begin
      grant_o     = own_onehot;
      req_ready_o = out_free ? own_onehot : '0;
      hs          = own_valid && out_free;
    end

    // A new byte overwrites the register; otherwise a consumed byte empties it
    if (hs) begin
      tx_valid_nxt = 1'b1;
      tx_data_nxt  = own_data;
    end else if (tx_valid_o && tx_ready_i) begin
      tx_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (|req_valid_i) begin
          state_nxt = LOCK;
          owner_nxt = pick;
        end
      end
      LOCK: begin
        if (hs && own_last) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
          cnt_nxt        = '0;
        end else if (own_valid) begin
          cnt_nxt = '0;
        end else if (HOLD_TIMEOUT > 0) begin
          // Owner went quiet mid-packet: release after HOLD_TIMEOUT idle cycles
          if (cnt == CNT_MAX) begin
            state_nxt      = IDLE;
            last_owner_nxt = owner;
            cnt_nxt        = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state == LOCK) || tx_valid_o;

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_RST;
      cnt        <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      cnt        <= cnt_nxt;
      tx_valid_o <= tx_valid_nxt;
      tx_data_o  <= tx_data_nxt;
    end
  end

  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!rst_i) $onehot0(grant_o));
  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_i) $onehot0(req_ready_o));
  a_ready_subset:  assert property (@(posedge clk_i) disable iff (!rst_i) (req_ready_o & ~grant_o) == '0);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: bench for uart_tx_arbiter with directed scenarios and randomized traffic against a reference model.
// Latency: model predicts every output each cycle; directed scenarios pin exact cycle positions.
// Backpressure: tx_ready_i is forced low/high or randomized per phase.
module tb_uart_tx_arbiter;

  localparam int N = 2;
  localparam int W = 8;
  localparam int T = 8;

  logic           clk = 1'b0;
  logic           rst_i = 1'b0;
  logic [N-1:0]   req_valid_i = '0;
  logic [N*W-1:0] req_data_i = '0;
  logic [N-1:0]   req_last_i = '0;
  logic [N-1:0]   req_ready_o;
  logic           tx_valid_o;
  logic [W-1:0]   tx_data_o;
  logic           tx_ready_i = 1'b1;
  logic [N-1:0]   grant_o;
  logic           busy_o;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .HOLD_TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Source queues ({last, byte}); test pushes, driver advances read pointers
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int rd0 = 0;
  int rd1 = 0;
  bit hs0 = 0;
  bit hs1 = 0;
  logic [7:0] log_q[$];
  int  rdy_mode = 1;   // 0 force low, 1 force high, 2 random
  bit  rand_gate = 0;

  // Reference model state
  bit        model_on = 0;
  int        m_own = -1;
  int        m_last = N - 1;
  int        m_idle = 0;
  bit        m_tv = 0;
  logic [7:0] m_td = '0;
  bit        m_room, m_take;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive requesters and serializer ready just after each rising edge
  always @(posedge clk) begin
    #1;
    if (hs0) rd0++;
    if (hs1) rd1++;
    tx_ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    req_valid_i[0] = (rd0 < q0.size()) && (!rand_gate || $urandom_range(0, 4) != 0);
    req_valid_i[1] = (rd1 < q1.size()) && (!rand_gate || $urandom_range(0, 4) != 0);
    {req_last_i[0], req_data_i[7:0]}  = (rd0 < q0.size()) ? q0[rd0] : 9'h0;
    {req_last_i[1], req_data_i[15:8]} = (rd1 < q1.size()) ? q1[rd1] : 9'h0;
  end

  // Reference model: what the arbiter must have done at this edge
  always @(posedge clk) begin
    if (!rst_i) begin
      m_own = -1; m_last = N - 1; m_idle = 0; m_tv = 0; m_td = '0; model_on = 1;
    end else if (model_on) begin
      m_room = !m_tv || tx_ready_i;
      m_take = (m_own >= 0) && req_valid_i[m_own] && m_room;
      if (m_take) begin
        m_tv = 1; m_td = req_data_i[m_own*W +: W];
      end else if (m_tv && tx_ready_i) begin
        m_tv = 0;
      end
      if (m_own < 0) begin
        m_idle = 0;
        for (int i = 1; i <= N; i++)
          if (m_own < 0 && req_valid_i[(m_last + i) % N]) m_own = (m_last + i) % N;
      end else if (m_take && req_last_i[m_own]) begin
        m_last = m_own; m_own = -1; m_idle = 0;
      end else if (req_valid_i[m_own]) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == T) begin
          m_last = m_own; m_own = -1; m_idle = 0;
        end
      end
    end
  end

  // Mid-cycle: record handshakes and delivered bytes, compare DUT with model
  always @(negedge clk) begin
    hs0 = rst_i && req_valid_i[0] && req_ready_o[0];
    hs1 = rst_i && req_valid_i[1] && req_ready_o[1];
    if (rst_i && tx_valid_o && tx_ready_i) log_q.push_back(tx_data_o);
    if (model_on) begin
      chk("tx_valid", tx_valid_o, m_tv);
      chk("tx_data", tx_data_o, m_td);
      chk("grant", grant_o, (m_own >= 0) ? (1 << m_own) : 0);
      chk("req_ready", req_ready_o, (m_own >= 0 && (!m_tv || tx_ready_i)) ? (1 << m_own) : 0);
      chk("busy", busy_o, (m_own >= 0) || m_tv);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_i = 1'b0;
    @(posedge clk); #1 rst_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_log(input string name, input int base, input logic [7:0] exp[$]);
    chk({name, " count"}, log_q.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (base + i < log_q.size()) chk(name, log_q[base + i], exp[i]);
  endtask

  task automatic push_pkt(input int who, input int len);
    logic [8:0] e;
    for (int i = 0; i < len; i++) begin
      e = {(i == len - 1), 8'($urandom)};
      if (who == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int base;
    int k;
    cyc(2);
    @(posedge clk); #1 rst_i = 1'b1;
    @(negedge clk);
    chk("reset busy", busy_o, 0);
    chk("reset grant", grant_o, 0);

    // 1: single packet from req0
    base = log_q.size();
    q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42}); q0.push_back({1'b1, 8'h43});
    @(negedge clk); chk("t1 grant c0", grant_o, 2'b00);
    @(negedge clk); chk("t1 grant c1", grant_o, 2'b01);
    @(negedge clk); chk("t1 data c2", {tx_valid_o, tx_data_o}, 9'h141);
    @(negedge clk); chk("t1 data c3", {tx_valid_o, tx_data_o}, 9'h142);
    @(negedge clk); chk("t1 data c4", {tx_valid_o, tx_data_o}, 9'h143);
    chk("t1 grant c4", grant_o, 2'b00);
    @(negedge clk); chk("t1 busy c5", busy_o, 0);
    chk_log("t1 log", base, '{8'h41, 8'h42, 8'h43});

    // 2: round-robin of single-byte packets from reset
    do_reset();
    base = log_q.size();
    q0.push_back({1'b1, 8'h10}); q0.push_back({1'b1, 8'h10});
    q1.push_back({1'b1, 8'h20}); q1.push_back({1'b1, 8'h20});
    @(negedge clk); chk("t2 grant c0", grant_o, 2'b00);
    @(negedge clk); chk("t2 grant c1", grant_o, 2'b01);
    @(negedge clk); chk("t2 grant c2", grant_o, 2'b00);
    @(negedge clk); chk("t2 grant c3", grant_o, 2'b10);
    cyc(8);
    chk_log("t2 order", base, '{8'h10, 8'h20, 8'h10, 8'h20});

    // 3: packet lock, req1 arrives after req0's first byte
    base = log_q.size();
    q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b0, 8'hA1});
    q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
    cyc(2);
    chk("t3 grant", grant_o, 2'b01);
    q1.push_back({1'b1, 8'hB0});
    k = 0;
    while (grant_o == 2'b01 && k < 20) begin
      chk("t3 ready1 held", req_ready_o[1], 0);
      @(negedge clk); k++;
    end
    chk("t3 lock released", grant_o != 2'b01, 1);
    cyc(6);
    chk_log("t3 order", base, '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0});

    // 4: backpressure for 10 cycles
    base = log_q.size();
    rdy_mode = 0;
    q0.push_back({1'b0, 8'h55}); q0.push_back({1'b1, 8'hAA});
    cyc(3);
    repeat (7) begin
      chk("t4 hold", {tx_valid_o, tx_data_o, req_ready_o[0]}, {1'b1, 8'h55, 1'b0});
      @(negedge clk);
    end
    rdy_mode = 1;
    cyc(5);
    chk_log("t4 log", base, '{8'h55, 8'hAA});

    // 5: owner timeout hands grant to pending req1
    base = log_q.size();
    q0.push_back({1'b0, 8'h77});
    @(negedge clk);
    q1.push_back({1'b1, 8'h88});
    @(negedge clk); chk("t5 grant c1", grant_o, 2'b01);
    @(negedge clk); chk("t5 byte c2", {tx_valid_o, tx_data_o}, 9'h177);
    cyc(7); chk("t5 grant c9", grant_o, 2'b01);
    @(negedge clk); chk("t5 grant c10", grant_o, 2'b00);
    @(negedge clk); chk("t5 grant c11", grant_o, 2'b10);
    cyc(4);
    chk_log("t5 log", base, '{8'h77, 8'h88});

    // 6: reset mid-packet of req1
    q0.push_back({1'b1, 8'hE0});
    cyc(6);
    q1.push_back({1'b0, 8'hC0}); q1.push_back({1'b0, 8'hC1}); q1.push_back({1'b1, 8'hC2});
    k = 0;
    while (!tx_valid_o && k < 20) begin @(negedge clk); k++; end
    chk("t6 wait tx_valid", {tx_valid_o, grant_o}, {1'b1, 2'b10});
    q0.push_back({1'b1, 8'hD0});
    @(posedge clk); #1 rst_i = 1'b0;
    @(posedge clk); #1 rst_i = 1'b1;
    @(negedge clk);
    chk("t6 outputs zero", {tx_valid_o, tx_data_o, grant_o, req_ready_o, busy_o}, 0);
    @(negedge clk); chk("t6 req0 wins", grant_o, 2'b01);
    cyc(10);

    // Randomized traffic with gated valids and random ready
    do_reset();
    rand_gate = 1; rdy_mode = 2;
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0 && q0.size() - rd0 < 12) push_pkt(0, $urandom_range(1, 5));
      if ($urandom_range(0, 9) == 0 && q1.size() - rd1 < 12) push_pkt(1, $urandom_range(1, 5));
    end
    rand_gate = 0; rdy_mode = 1;
    k = 0;
    while ((rd0 < q0.size() || rd1 < q1.size() || busy_o) && k < 500) begin @(negedge clk); k++; end
    chk("drain q0", rd0, q0.size());
    chk("drain q1", rd1, q1.size());
    chk("drain busy", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin, packet-locking arbiter that shares the board's single UART transmitter between NUM_REQ byte-stream requesters, for example the CPU's MMIO UART path and a debug/boot-status source. It sits inside top, between the requesters and the UART TX serializer. It presents one registered valid/ready byte stream to the serializer and holds a grant for a whole packet, so packets from different requesters never interleave on uart_tx_o.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 8, byte width per requester
HOLD_TIMEOUT, 1024, consecutive idle cycles of the owner (no req_valid) before the grant is forcibly released; 0 disables the timeout

Ports:
clk_i  input  1  system clock (50 MHz domain)
rst_i  input  1  synchronous reset, active-low
req_valid_i  input  NUM_REQ  per-requester byte valid
req_data_i  input  NUM_REQ*DATA_W  per-requester byte; requester k occupies bits [k*DATA_W +: DATA_W]
req_last_i  input  NUM_REQ  marks the final byte of a packet (qualified by valid)
req_ready_o  output  NUM_REQ  per-requester accept strobe
tx_valid_o  output  1  byte available to the serializer
tx_data_o  output  DATA_W  byte to the serializer
tx_ready_i  input  1  serializer accepts the byte this cycle
grant_o  output  NUM_REQ  one-hot current owner; all zero when idle
busy_o  output  1  high in LOCK or while tx_valid_o is high

Behaviour:
- Reset (rst_i==0 at a clk_i edge): state=IDLE, tx_valid_o=0, tx_data_o=0, grant_o=0, req_ready_o=0, busy_o=0, last_owner=NUM_REQ-1, timeout counter=0. Reset mid-packet discards the pending output byte. No handshake occurs on the reset cycle.
- FSM states: IDLE and LOCK.
- IDLE behaviour:
  - req_ready_o is all zero.
  - If any req_valid_i bit is high, the owner is the first set bit found when searching from (last_owner+1) mod NUM_REQ upward with wrap.
  - The owner is latched, grant_o is driven one-hot and the FSM moves to LOCK on the next edge.
  - Grant latency is 1 cycle from req_valid_i.
- LOCK behaviour:
  - req_ready_o[owner] = (!tx_valid_o || tx_ready_i); all other ready bits are 0.
  - Ready does not depend combinationally on req_valid_i.
  - Owner handshake (valid && ready): tx_data_o <= owner's byte and tx_valid_o <= 1 on the next edge. First byte reaches tx_valid_o 2 cycles after req_valid_i when the output stage is empty.
  - Handshake with req_last_i=1: the FSM goes to IDLE, last_owner <= owner and grant_o <= 0 on the same edge.
- Output register:
  - If tx_valid_o && tx_ready_i and there is no new owner handshake, tx_valid_o <= 0.
  - While tx_ready_i is low, tx_valid_o and tx_data_o hold stable.
  - Full throughput is one byte per cycle when tx_ready_i is held high.
- Timeout, active only when HOLD_TIMEOUT>0:
  - In LOCK, the counter increments every cycle that req_valid_i[owner]==0 and clears on any owner valid.
  - When the counter reaches HOLD_TIMEOUT-1 with the owner still idle, the FSM moves to IDLE, last_owner <= owner and the counter clears.
  - A byte already in the output register is still delivered.
  - The counter width is clog2(HOLD_TIMEOUT+1).
- Handover:
  - The new owner can be granted in the cycle after release even if tx_valid_o is still high.
  - Its ready stays low until the output register frees.
  - There is no dead cycle beyond the 1-cycle IDLE arbitration.
- Simultaneous events:
  - Owner last-byte and other requests in the same cycle: arbitration happens in the following IDLE cycle, using the updated last_owner.
  - Non-owner valids never affect LOCK.
- busy_o = (state==LOCK) || tx_valid_o.
- Assertions:
  - grant_o is one-hot0.
  - At most one req_ready_o bit is high.
  - req_ready_o is a subset of grant_o.

Test Plan:
1. Single packet: req0 sends 0x41,0x42,0x43 (last on 0x43) with tx_ready_i=1 -> grant_o=01 at cycle 1, tx_data_o shows 0x41,0x42,0x43 on cycles 2-4, grant_o=00 at cycle 4, busy_o low at cycle 5.
2. Round-robin: req0 and req1 both assert 1-byte packets (0x10, 0x20) from reset, repeated twice -> serializer order is 0x10, 0x20, 0x10, 0x20; each grant lasts exactly one packet.
3. Packet lock: req0 sends 4 bytes, req1 raises valid after req0's first byte -> req_ready_o[1]=0 until req0's last handshake; req1's byte appears only after all 4 req0 bytes.
4. Backpressure: tx_ready_i=0 for 10 cycles with req0 streaming 0x55,0xAA -> tx_data_o holds 0x55 with tx_valid_o=1, req_ready_o[0]=0, and no byte is lost or duplicated after release.
5. Timeout: HOLD_TIMEOUT=8; req0 sends one non-last byte then drops valid while req1 is pending -> grant moves to req1 after exactly 8 idle cycles plus 1 arbitration cycle.
6. Reset mid-packet: pull rst_i low for 1 cycle during req1's packet with tx_valid_o=1 -> all outputs read zero on the next cycle and req0 wins the next arbitration.
